// File: rtl/branch_resolve_bht.sv
// Branch resolution stage with a 2-bit saturating-counter BHT and registered redirect.
// Optional performance counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_resolve_bht #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            BrUn,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_br,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int unsigned BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           r_bht [BHT_N];
  logic [BHT_IDX_W-1:0] w_if_idx;
  logic [BHT_IDX_W-1:0] w_ex_idx;
  logic                 w_res;
  logic                 w_legal;
  logic                 w_actual;
  logic                 w_upd;
  logic                 w_mispred;
  logic                 w_illegal;
  logic [1:0]           w_cur;
  logic [1:0]           w_bht_next;
  logic                 w_unused;

  assign w_if_idx      = if_pc[BHT_IDX_W+1:2];
  assign w_ex_idx      = ex_pc[BHT_IDX_W+1:2];
  assign if_pred_taken = r_bht[w_if_idx][1];
  assign w_unused      = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

  assign BrUn = (ex_funct3[2:1] == 2'b11);

  // Branches in the redirect cycle are wrong-path and must have no side effects.
  assign w_res     = ex_valid & ex_is_branch & ~redirect_valid;
  assign w_legal   = (ex_funct3[2:1] != 2'b01);
  assign w_upd     = w_res & w_legal;
  assign w_mispred = w_upd & (w_actual != ex_pred_taken);
  assign w_illegal = w_res & ~w_legal;

  always_comb begin
    w_actual = 1'b0;
    case (ex_funct3)
      3'b000:  w_actual = BrEq;
      3'b001:  w_actual = ~BrEq;
      3'b100:  w_actual = BrLT;
      3'b101:  w_actual = ~BrLT;
      3'b110:  w_actual = BrLT;
      3'b111:  w_actual = ~BrLT;
      default: w_actual = 1'b0;
    endcase
  end

  always_comb begin
    w_cur      = r_bht[w_ex_idx];
    w_bht_next = w_cur;
    if (w_actual) begin
      if (w_cur != 2'b11) w_bht_next = w_cur + 2'b01;
    end else begin
      if (w_cur != 2'b00) w_bht_next = w_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_N; i++) begin
        r_bht[i[BHT_IDX_W-1:0]] <= 2'b01;
      end
    end else if (w_upd) begin
      r_bht[w_ex_idx] <= w_bht_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      illegal_br     <= 1'b0;
    end else begin
      redirect_valid <= w_mispred;
      illegal_br     <= w_illegal;
      if (w_mispred) begin
        redirect_pc <= w_actual ? ex_target : (ex_pc + XLEN'(4));
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_upd)     r_br_count      <= r_br_count + 32'd1;
      if (w_mispred) r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed self-checking bench for branch_resolve_bht.
module tb_branch_resolve_bht;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        BrUn;
  logic        BrEq;
  logic        BrLT;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        illegal_br;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int checks;
  int failures;

`ifdef BRANCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  branch_resolve_bht #(.XLEN(32), .BHT_IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .BrUn(BrUn), .BrEq(BrEq), .BrLT(BrLT),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal_br(illegal_br), .br_count(br_count), .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    ex_valid      = 1'b0;
    ex_is_branch  = 1'b0;
    ex_funct3     = 3'b000;
    ex_pc         = '0;
    ex_target     = '0;
    ex_pred_taken = 1'b0;
    BrEq          = 1'b0;
    BrLT          = 1'b0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic eq, input logic lt);
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
    BrEq          = eq;
    BrLT          = lt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    if_pc = 32'h100;
    rst_n = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    checks++; if (illegal_br !== 1'b0) begin failures++; $display("FAIL reset_ill got=%b exp=0", illegal_br); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", if_pred_taken); end
    checks++; if (br_count !== 32'h0) begin failures++; $display("FAIL reset_brcnt got=%h exp=0", br_count); end
    checks++; if (mispred_count !== 32'h0) begin failures++; $display("FAIL reset_mpcnt got=%h exp=0", mispred_count); end
  endtask

  task automatic test_beq_mispredict();
    if_pc = 32'h100;
    branch(3'b000, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_rv got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h80) begin failures++; $display("FAIL beq_rpc got=%h exp=80", redirect_pc); end
    checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL beq_pred got=%b exp=1", if_pred_taken); end
    step();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_rv_pulse got=%b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h80) begin failures++; $display("FAIL beq_rpc_hold got=%h exp=80", redirect_pc); end
  endtask

  task automatic test_brun();
    logic [2:0] f3v [4] = '{3'b111, 3'b101, 3'b110, 3'b000};
    logic       expv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ex_funct3 = f3v[i];
      #1;
      checks++; if (BrUn !== expv[i]) begin failures++; $display("FAIL brun_f3_%b got=%b exp=%b", f3v[i], BrUn, expv[i]); end
    end
    // BGEU with BrLT=1 is not taken; index 0 currently holds 10.
    if_pc = 32'h200;
    branch(3'b111, 32'h200, 32'h40, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL bgeu_rv got=%b exp=0", redirect_valid); end
    checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL bgeu_pred got=%b exp=0", if_pred_taken); end
  endtask

  task automatic test_counter_seq();
    logic        eqv   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        predv [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        rvv   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] rpcv  [4] = '{32'h900, 32'h900, 32'h900, 32'h144};
    if_pc = 32'h140;
    for (int i = 0; i < 4; i++) begin
      branch(3'b001, 32'h140, 32'h900, predv[i], eqv[i], 1'b0);
      #1;
      checks++; if (if_pred_taken !== predv[i]) begin failures++; $display("FAIL seq_prefetch_%0d got=%b exp=%b", i, if_pred_taken, predv[i]); end
      step();
      idle();
      checks++; if (redirect_valid !== rvv[i]) begin failures++; $display("FAIL seq_rv_%0d got=%b exp=%b", i, redirect_valid, rvv[i]); end
      checks++; if (redirect_pc !== rpcv[i]) begin failures++; $display("FAIL seq_rpc_%0d got=%h exp=%h", i, redirect_pc, rpcv[i]); end
      checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL seq_pred_%0d got=%b exp=1", i, if_pred_taken); end
      step();
    end
    if_pc = 32'h1143;
    #1;
    checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL alias_pred got=%b exp=1", if_pred_taken); end
  endtask

  task automatic test_wrap();
    branch(3'b000, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL wrap_rv got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL wrap_rpc got=%h exp=0", redirect_pc); end
    step();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    branch(3'b000, 32'h300, 32'h700, 1'b0, 1'b1, 1'b0);
    step();
    branch(3'b001, 32'h304, 32'h800, 1'b0, 1'b0, 1'b0);
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL b2b_rv1 got=%b exp=1", redirect_valid); end
    step();
    idle();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL b2b_rv2 got=%b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h700) begin failures++; $display("FAIL b2b_rpc got=%h exp=700", redirect_pc); end
    if_pc = 32'h304;
    #1;
    checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL b2b_pred got=%b exp=0", if_pred_taken); end
    checks++; if (br_count !== (PERF ? 32'd1 : 32'd0)) begin failures++; $display("FAIL b2b_brcnt got=%0d exp=%0d", br_count, PERF ? 1 : 0); end
    checks++; if (mispred_count !== (PERF ? 32'd1 : 32'd0)) begin failures++; $display("FAIL b2b_mpcnt got=%0d exp=%0d", mispred_count, PERF ? 1 : 0); end
  endtask

  task automatic test_illegal();
    if_pc = 32'h408;
    branch(3'b010, 32'h408, 32'hA00, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    checks++; if (illegal_br !== 1'b1) begin failures++; $display("FAIL ill_pulse got=%b exp=1", illegal_br); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL ill_rv got=%b exp=0", redirect_valid); end
    step();
    checks++; if (illegal_br !== 1'b0) begin failures++; $display("FAIL ill_clear got=%b exp=0", illegal_br); end
    // Entry must still be 01: one taken branch moves it to 10.
    branch(3'b000, 32'h408, 32'hA00, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL ill_bht got=%b exp=1", if_pred_taken); end
    checks++; if (redirect_pc !== 32'hA00) begin failures++; $display("FAIL ill_rpc got=%h exp=a00", redirect_pc); end
    checks++; if (br_count !== (PERF ? 32'd2 : 32'd0)) begin failures++; $display("FAIL ill_brcnt got=%0d exp=%0d", br_count, PERF ? 2 : 0); end
    step();
  endtask

  task automatic test_async_reset();
    if_pc = 32'h500;
    branch(3'b000, 32'h500, 32'hB00, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL ar_rv_pre got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h504) begin failures++; $display("FAIL ar_rpc_pre got=%h exp=504", redirect_pc); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL ar_rv got=%b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL ar_rpc got=%h exp=0", redirect_pc); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL ar_pred_%0d got=%b exp=0", i, if_pred_taken); end
    end
    checks++; if (mispred_count !== 32'h0) begin failures++; $display("FAIL ar_mpcnt got=%h exp=0", mispred_count); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    if_pc    = '0;
    idle();
    test_reset();
    test_beq_mispredict();
    test_brun();
    test_counter_seq();
    test_wrap();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
